prog_loader: RTL and testbench



---
 rtl/prog_loader.sv | 112 +++++++++++
 tb/tb_prog_loader.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: streams a byte program into instruction memory as 16-bit
// words, then releases the core from reset; halt sends it back to IDLE.
//
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   ld_start,ld_len load request and program length in words
//   halt            return to IDLE and hold the core in reset
//   in_data,in_valid,in_ready   byte stream handshake
//   im_we,im_waddr,im_wdata     instruction memory write port
//   core_rst_n      core reset (active-low)
//   busy,done,err   status: loading, running, sticky length error
module prog_loader #(
  parameter int MAX_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_start,
  input  logic [7:0]  ld_len,
  input  logic        halt,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        im_we,
  output logic [7:0]  im_waddr,
  output logic [15:0] im_wdata,
  output logic        core_rst_n,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE,
    LO,
    HI,
    WRITE,
    RUN
  } state_t;

  state_t      state;
  logic [6:0]  wcnt;
  logic [7:0]  len;
  logic [7:0]  lo;
  logic        len_ok;
  logic        last;

  assign len_ok = (32'(ld_len) <= MAX_WORDS);
  assign last   = (({1'b0, wcnt} + 8'd1) == len);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      wcnt     <= '0;
      len      <= '0;
      lo       <= '0;
      im_waddr <= '0;
      im_wdata <= '0;
      err      <= 1'b0;
    end else if (halt && state != IDLE) begin
      // halt wins over any handshake or write this cycle;
      // a half-assembled word is simply dropped
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (ld_start) begin
            if (ld_len == 8'd0) begin
              err   <= 1'b0;
              state <= RUN;
            end else if (len_ok) begin
              err   <= 1'b0;
              wcnt  <= '0;
              len   <= ld_len;
              state <= LO;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LO: begin
          if (in_valid) begin
            lo    <= in_data;
            state <= HI;
          end
        end
        HI: begin
          if (in_valid) begin
            im_wdata <= {in_data, lo};
            im_waddr <= {wcnt, 1'b0};
            state    <= WRITE;
          end
        end
        WRITE: begin
          wcnt  <= wcnt + 7'd1;
          state <= last ? RUN : LO;
        end
        RUN: begin
          state <= RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state == LO) || (state == HI);
  assign busy       = (state == LO) || (state == HI) || (state == WRITE);
  assign done       = (state == RUN);
  assign core_rst_n = (state == RUN);
  // the strobe is masked by halt so a halt seen in WRITE commits nothing
  assign im_we      = (state == WRITE) && !halt;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: self-checking bench for prog_loader.
// Table vectors for start decisions, directed corner cases, random loads.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld_start = 1'b0;
  logic [7:0]  ld_len = 8'd0;
  logic        halt = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        im_we;
  logic [7:0]  im_waddr;
  logic [15:0] im_wdata;
  logic        core_rst_n;
  logic        busy;
  logic        done;
  logic        err;

  int pass_n = 0;
  int total_n = 0;
  int bad_ready = 0;
  int bad_pulse = 0;
  logic prev_we = 1'b0;

  logic [23:0] wq[$];
  logic [7:0]  prog[$];

  always #5 clk = ~clk;

  prog_loader #(.MAX_WORDS(128)) dut (
    .clk(clk),
    .rst(rst),
    .ld_start(ld_start),
    .ld_len(ld_len),
    .halt(halt),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .im_we(im_we),
    .im_waddr(im_waddr),
    .im_wdata(im_wdata),
    .core_rst_n(core_rst_n),
    .busy(busy),
    .done(done),
    .err(err)
  );

  // memory-side observer: record every committed write
  always @(negedge clk) begin
    if (im_we) wq.push_back({im_waddr, im_wdata});
    if (in_ready && !(busy && !im_we)) bad_ready++;
    if (im_we && prev_we) bad_pulse++;
    prev_we = im_we;
  end

  function automatic void check(string nm, logic [31:0] act,
                                logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic start(input logic [7:0] n);
    ld_start = 1'b1;
    ld_len = n;
    @(posedge clk); #1;
    ld_start = 1'b0;
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit h);
    in_valid = v;
    in_data = d;
    halt = h;
    @(posedge clk); #1;
    in_valid = 1'b0;
    halt = 1'b0;
  endtask

  // load prog[0..2n-1]; mode 0 continuous, 1 toggling, 2 random valid.
  // cyc counts edges after the start edge until done is seen.
  task automatic load(input int n, input int mode, output int cyc);
    int idx;
    bit v;
    logic [23:0] exp;
    logic [23:0] got;
    wq.delete();
    start(8'(n));
    idx = 0;
    cyc = 0;
    while (!done && cyc < 8 * n + 50) begin
      if (mode == 0) v = 1'b1;
      else if (mode == 1) v = (cyc % 2 == 0);
      else v = 1'($urandom_range(0, 1));
      in_valid = v;
      in_data = (idx < 2 * n) ? prog[idx] : 8'($urandom);
      @(negedge clk);
      if (v && in_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check("load_done", 32'(done), 32'd1);
    check("load_nwrites", wq.size(), n);
    check("load_bytes_used", idx, 2 * n);
    for (int i = 0; i < n; i++) begin
      exp = {8'(2 * i), prog[2 * i + 1], prog[2 * i]};
      got = (i < wq.size()) ? wq[i] : 24'hxxxxxx;
      check($sformatf("write%0d", i), 32'(got), 32'(exp));
    end
  endtask

  typedef struct {
    logic [7:0] len;
    bit e_err;
    bit e_busy;
    bit e_done;
    bit e_ready;
  } vec_t;

  vec_t vt[6];

  initial begin
    int cyc;
    int n;

    vt[0] = '{8'd0,   1'b0, 1'b0, 1'b1, 1'b0};
    vt[1] = '{8'd1,   1'b0, 1'b1, 1'b0, 1'b1};
    vt[2] = '{8'd64,  1'b0, 1'b1, 1'b0, 1'b1};
    vt[3] = '{8'd128, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[4] = '{8'd129, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[5] = '{8'd255, 1'b1, 1'b0, 1'b0, 1'b0};

    do_reset();
    check("rst_ready", 32'(in_ready), 0);
    check("rst_we", 32'(im_we), 0);
    check("rst_waddr", 32'(im_waddr), 0);
    check("rst_wdata", 32'(im_wdata), 0);
    check("rst_core", 32'(core_rst_n), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);

    // start decision vectors: one edge after ld_start
    foreach (vt[i]) begin
      do_reset();
      start(vt[i].len);
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vt[i].e_err));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].e_busy));
      check($sformatf("vec%0d_done", i), 32'(done), 32'(vt[i].e_done));
      check($sformatf("vec%0d_ready", i), 32'(in_ready),
            32'(vt[i].e_ready));
      check($sformatf("vec%0d_core", i), 32'(core_rst_n),
            32'(vt[i].e_done));
    end

    // basic load
    do_reset();
    prog = '{8'h10, 8'hA5, 8'h20, 8'h3C};
    load(2, 0, cyc);
    check("basic_latency", cyc, 6);
    check("basic_core", 32'(core_rst_n), 1);

    // back-pressure
    step(1'b0, 8'h00, 1'b1);
    load(2, 1, cyc);

    // length errors
    do_reset();
    wq.delete();
    start(8'd200);
    step(1'b1, 8'h55, 1'b0);
    step(1'b1, 8'h66, 1'b0);
    check("lenerr_err", 32'(err), 1);
    check("lenerr_busy", 32'(busy), 0);
    check("lenerr_done", 32'(done), 0);
    start(8'd0);
    check("len0_err", 32'(err), 0);
    check("len0_done", 32'(done), 1);
    check("len0_core", 32'(core_rst_n), 1);
    check("lenerr_nwrites", wq.size(), 0);

    // halt mid-load after four accepted bytes
    step(1'b0, 8'h00, 1'b1);
    wq.delete();
    start(8'd3);
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    step(1'b1, 8'h44, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h55, 1'b1);
    check("halt_busy", 32'(busy), 0);
    check("halt_core", 32'(core_rst_n), 0);
    check("halt_ready", 32'(in_ready), 0);
    check("halt_nwrites", wq.size(), 2);
    if (wq.size() == 2) begin
      check("halt_w0", 32'(wq[0]), 32'h00_2211);
      check("halt_w1", 32'(wq[1]), 32'h02_4433);
    end
    prog = '{8'hAB, 8'hCD};
    load(1, 0, cyc);

    // RUN ignores ld_start; halt returns to IDLE
    ld_start = 1'b1;
    ld_len = 8'd5;
    step(1'b1, 8'h99, 1'b0);
    ld_start = 1'b0;
    check("run_ignore_done", 32'(done), 1);
    check("run_ignore_busy", 32'(busy), 0);
    step(1'b0, 8'h00, 1'b1);
    check("run_halt_done", 32'(done), 0);
    check("run_halt_core", 32'(core_rst_n), 0);

    // halt seen in WRITE suppresses the write
    wq.delete();
    start(8'd2);
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check("halt_wr_nwrites", wq.size(), 0);
    check("halt_wr_busy", 32'(busy), 0);

    // reset while in HI
    prog = '{8'hE1, 8'hF2};
    load(1, 0, cyc);
    step(1'b0, 8'h00, 1'b1);
    start(8'd2);
    step(1'b1, 8'h77, 1'b0);
    rst = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h88;
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    check("mrst_ready", 32'(in_ready), 0);
    check("mrst_we", 32'(im_we), 0);
    check("mrst_waddr", 32'(im_waddr), 0);
    check("mrst_wdata", 32'(im_wdata), 0);
    check("mrst_core", 32'(core_rst_n), 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_done", 32'(done), 0);
    check("mrst_err", 32'(err), 0);

    // full-size program
    prog.delete();
    for (int i = 0; i < 256; i++) prog.push_back(8'($urandom));
    load(128, 0, cyc);
    check("full_latency", cyc, 384);
    if (wq.size() == 128) check("full_last_addr", 32'(wq[127][23:16]), 32'hFE);

    // random loads with random valid gaps
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 8'h00, 1'b1);
      n = $urandom_range(1, 12);
      prog.delete();
      for (int i = 0; i < 2 * n; i++) prog.push_back(8'($urandom));
      load(n, 2, cyc);
    end

    check("ready_only_lo_hi", bad_ready, 0);
    check("we_single_pulse", bad_pulse, 0);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
